// File: rtl/key_repeat_encoder_if.sv
// Direction-key levels in, one-cycle move commands out, between the PS/2
// keyboard decoder and the game controller.
interface key_repeat_encoder_if;
    logic       enable;
    logic       left;
    logic       right;
    logic       up;
    logic [1:0] keyboard_signal;
    logic       repeating;

    modport master (
        output enable, left, right, up,
        input  keyboard_signal, repeating
    );

    modport slave (
        input  enable, left, right, up,
        output keyboard_signal, repeating
    );
endinterface

// File: rtl/key_repeat_encoder.sv
// Turns held direction keys into single-cycle move commands: one command per
// press, with auto-repeat for left/right after an initial delay.
module key_repeat_encoder #(
    parameter int unsigned DELAY_CYCLES  = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 8_000_000
) (
    input  logic                 clk,
    input  logic                 clrn,
    key_repeat_encoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_LEFT  = 2'b01;
    localparam logic [1:0] CODE_RIGHT = 2'b10;
    localparam logic [1:0] CODE_ROT   = 2'b11;

    localparam logic [31:0] DELAY_LAST  = 32'(DELAY_CYCLES - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

    logic [2:0]  key_q;
    logic        en_q;
    logic [1:0]  state, state_nx;
    logic [1:0]  cur, cur_nx;
    logic [31:0] cnt, cnt_nx;
    logic [1:0]  emit_nx;
    logic [1:0]  resolved;
    logic [1:0]  ks_q;
    logic        rep_q;

    // Input capture: enable is registered with the keys so a key already held
    // when enable rises sees the same two-edge latency as a fresh press.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_q <= 3'b000;
            en_q  <= 1'b0;
        end else begin
            key_q <= {bus.left, bus.right, bus.up};
            en_q  <= bus.enable;
        end
    end

    always_comb begin
        resolved = CODE_NONE;
        if (key_q[2])      resolved = CODE_LEFT;
        else if (key_q[1]) resolved = CODE_RIGHT;
        else if (key_q[0]) resolved = CODE_ROT;
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        cnt_nx   = cnt;
        emit_nx  = CODE_NONE;
        if (!en_q) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else if (state == S_IDLE) begin
            cnt_nx = '0;
            if (resolved != CODE_NONE) begin
                emit_nx  = resolved;
                cur_nx   = resolved;
                state_nx = S_DELAY;
            end
        end else if (resolved == CODE_NONE) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else if (resolved != cur) begin
            // A change of the winning key (including releasing a higher-priority one) is a new press.
            emit_nx  = resolved;
            cur_nx   = resolved;
            cnt_nx   = '0;
            state_nx = S_DELAY;
        end else begin
            case (state)
                S_DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        cnt_nx = '0;
                        if (cur == CODE_ROT) begin
                            state_nx = S_HOLD;
                        end else begin
                            emit_nx  = cur;
                            state_nx = S_REPEAT;
                        end
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                S_REPEAT: begin
                    if (cnt == REPEAT_LAST) begin
                        emit_nx = cur;
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command stage
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
            cur   <= CODE_NONE;
            cnt   <= '0;
            ks_q  <= CODE_NONE;
            rep_q <= 1'b0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            cnt   <= cnt_nx;
            ks_q  <= emit_nx;
            rep_q <= (state_nx == S_REPEAT);
        end
    end

    assign bus.keyboard_signal = ks_q;
    assign bus.repeating       = rep_q;
endmodule

// File: tb/tb_key_repeat_encoder.sv
// Directed bench for key_repeat_encoder with DELAY_CYCLES=10, REPEAT_CYCLES=4;
// every command pulse is logged with its cycle number and compared to a hand-built list.
module tb_key_repeat_encoder;
    localparam int DELAY = 10;
    localparam int REP   = 4;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    key_repeat_encoder_if bus();

    key_repeat_encoder #(
        .DELAY_CYCLES (DELAY),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         log_cyc[$];
    logic [1:0] log_code[$];
    int         exp_cyc[$];
    logic [1:0] exp_code[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger: cyc is the number of the edge that registered the command.
    always @(negedge clk) begin
        if (bus.keyboard_signal != 2'b00) begin
            log_cyc.push_back(cyc);
            log_code.push_back(bus.keyboard_signal);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_code.delete();
        exp_cyc.delete();
        exp_code.delete();
    endtask

    task automatic expect_pulse(input int c, input logic [1:0] code);
        exp_cyc.push_back(c);
        exp_code.push_back(code);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 32'(log_cyc.size()), 32'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < log_cyc.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), 32'(log_cyc[i]), 32'(exp_cyc[i]));
            check($sformatf("%s_code%0d", tag, i), 32'(log_code[i]), 32'(exp_code[i]));
        end
        clear_log();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t0;
        int t1;
        int r;
        bus.enable = 1'b1;
        bus.left   = 1'b0;
        bus.right  = 1'b0;
        bus.up     = 1'b0;
        clrn       = 1'b0;
        tick(3);
        check("rst_ks", 32'(bus.keyboard_signal), 0);
        check("rst_rep", 32'(bus.repeating), 0);
        clrn = 1'b1;
        tick(3);
        clear_log();

        // Tap: one pulse, two edges after the press
        t0 = cyc;
        bus.left = 1'b1;
        tick(3);
        bus.left = 1'b0;
        tick(20);
        expect_pulse(t0 + 2, 2'b01);
        compare_log("tap");

        // Left held 30 cycles
        t0 = cyc;
        bus.left = 1'b1;
        wait_cyc(t0 + 11);
        check("hold_rep_pre", 32'(bus.repeating), 0);
        wait_cyc(t0 + 12);
        check("hold_rep_on", 32'(bus.repeating), 1);
        wait_cyc(t0 + 30);
        bus.left = 1'b0;
        wait_cyc(t0 + 31);
        check("hold_rep_tail", 32'(bus.repeating), 1);
        wait_cyc(t0 + 32);
        check("hold_rep_off", 32'(bus.repeating), 0);
        tick(10);
        expect_pulse(t0 + 2,  2'b01);
        expect_pulse(t0 + 12, 2'b01);
        expect_pulse(t0 + 16, 2'b01);
        expect_pulse(t0 + 20, 2'b01);
        expect_pulse(t0 + 24, 2'b01);
        expect_pulse(t0 + 28, 2'b01);
        compare_log("hold");

        // Rotate held 40 cycles, then pressed again
        t0 = cyc;
        bus.up = 1'b1;
        wait_cyc(t0 + 20);
        check("rot_rep", 32'(bus.repeating), 0);
        wait_cyc(t0 + 40);
        bus.up = 1'b0;
        tick(5);
        t1 = cyc;
        bus.up = 1'b1;
        tick(5);
        bus.up = 1'b0;
        tick(10);
        expect_pulse(t0 + 2, 2'b11);
        expect_pulse(t1 + 2, 2'b11);
        compare_log("rot");

        // Priority: right added under left, then left released
        t0 = cyc;
        bus.left = 1'b1;
        wait_cyc(t0 + 5);
        bus.right = 1'b1;
        wait_cyc(t0 + 20);
        bus.left = 1'b0;
        wait_cyc(t0 + 37);
        bus.right = 1'b0;
        tick(15);
        expect_pulse(t0 + 2,  2'b01);
        expect_pulse(t0 + 12, 2'b01);
        expect_pulse(t0 + 16, 2'b01);
        expect_pulse(t0 + 20, 2'b01);
        expect_pulse(t0 + 22, 2'b10);
        expect_pulse(t0 + 32, 2'b10);
        expect_pulse(t0 + 36, 2'b10);
        compare_log("prio");

        // Enable gating
        t0 = cyc;
        bus.enable = 1'b0;
        bus.right  = 1'b1;
        wait_cyc(t0 + 10);
        bus.enable = 1'b1;
        wait_cyc(t0 + 32);
        bus.enable = 1'b0;
        wait_cyc(t0 + 33);
        check("en_rep_hold", 32'(bus.repeating), 1);
        wait_cyc(t0 + 34);
        check("en_rep_drop", 32'(bus.repeating), 0);
        tick(10);
        bus.right = 1'b0;
        tick(3);
        bus.enable = 1'b1;
        tick(10);
        expect_pulse(t0 + 12, 2'b10);
        expect_pulse(t0 + 22, 2'b10);
        expect_pulse(t0 + 26, 2'b10);
        expect_pulse(t0 + 30, 2'b10);
        compare_log("en");

        // Asynchronous reset in the middle of REPEAT
        t0 = cyc;
        bus.left = 1'b1;
        wait_cyc(t0 + 16);
        check("rstmid_ks_pre", 32'(bus.keyboard_signal), 1);
        check("rstmid_rep_pre", 32'(bus.repeating), 1);
        clrn = 1'b0;
        #1;
        check("rstmid_ks", 32'(bus.keyboard_signal), 0);
        check("rstmid_rep", 32'(bus.repeating), 0);
        tick(2);
        clear_log();
        clrn = 1'b1;
        r = cyc;
        tick(6);
        expect_pulse(r + 2, 2'b01);
        compare_log("rstrel");
        bus.left = 1'b0;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
